warmboot_ctrl: RTL and testbench
================================

Name: warmboot_ctrl

Overview:
Sequencer that drives the iCE40 SB_WARMBOOT primitive (S1, S0, BOOT) in place of a free-running counter compare. It accepts a single image-select request over a valid/ready handshake and waits a programmable arming delay, during which the request can be cancelled. It then holds the image-select lines stable for a setup window before asserting BOOT. It sits between the design logic that decides to reconfigure and the SB_WARMBOOT instance, next to the BRAM-backed datapath.

Parameters:
DELAY_CYCLES, 120_000_000, arming delay in clk cycles (5 s at 24 MHz); 0 allowed.
SETUP_CYCLES, 16, cycles S1/S0 held stable before BOOT rises; must be >= 1 (elaboration error otherwise).
CNT_W, 30, counter width; must satisfy 2^CNT_W > max(DELAY_CYCLES, SETUP_CYCLES).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  boot request valid.
req_image  input  2  target image index {S1,S0}.
req_ready  output  1  high only in IDLE.
cancel  input  1  abort an armed request.
armed  output  1  high in ARMED.
busy  output  1  high in ARMED, SETUP or BOOT.
s1  output  1  to SB_WARMBOOT.S1.
s0  output  1  to SB_WARMBOOT.S0.
boot  output  1  to SB_WARMBOOT.BOOT.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs are registered or decoded from registered state.
- Reset values: state=IDLE, counter=0, image latch=0, s1=s0=0, boot=0, armed=0, busy=0, req_ready=1 once out of reset.
- States:
  - IDLE:
    - req_ready=1.
    - On the edge where req_valid&&req_ready: latch req_image and clear counter.
    - Next state is ARMED, or SETUP if DELAY_CYCLES==0.
    - cancel is ignored.
  - ARMED:
    - Counter increments each cycle.
    - When counter==DELAY_CYCLES-1 on an edge: go to SETUP and clear counter.
    - ARMED lasts exactly DELAY_CYCLES cycles.
    - cancel=1 on any ARMED edge: go to IDLE, clear counter and image latch, s1/s0 return to 0.
    - cancel takes priority over terminal count on the same edge.
  - SETUP:
    - Counter increments.
    - When counter==SETUP_CYCLES-1: go to BOOT.
    - cancel is ignored (committed).
  - BOOT:
    - boot=1, held indefinitely; terminal.
    - Only rst_n exits (the device reconfigures regardless).
- s1/s0: driven from the image latch in ARMED, SETUP and BOOT; 0 in IDLE. They are stable for at least SETUP_CYCLES cycles before boot rises and do not change while boot=1.
- Latency: boot rises exactly DELAY_CYCLES+SETUP_CYCLES clock edges after the accepting edge.
- Handshake:
  - Requests with req_ready=0 are not accepted and not queued.
  - req_image changes after acceptance have no effect.
- Counter: never wraps; it is compared against terminal values only.
- Reset mid-operation (any state): immediately returns to reset values, and boot deasserts asynchronously.

Test Plan:
1. DELAY_CYCLES=10, SETUP_CYCLES=4; release reset, pulse req_valid with req_image=2'b10 -> req_ready drops next cycle; armed high for 10 cycles; s1=1, s0=0 from the cycle after acceptance; boot rises exactly 14 edges after the accepting edge and stays high.
2. Same params; accept req_image=2'b01; assert cancel on the 5th ARMED cycle -> next cycle IDLE, req_ready=1, s1=s0=0, boot never rises; a new request with 2'b11 then boots after 14 edges with s1=s0=1.
3. cancel asserted on the same edge as ARMED terminal count (counter=9) -> returns to IDLE, no SETUP entered. cancel asserted during SETUP -> ignored, boot rises on schedule.
4. Hold req_valid high with changing req_image while busy -> no second acceptance; s1/s0 keep the first latched value through BOOT.
5. DELAY_CYCLES=0, SETUP_CYCLES=1 -> accept goes directly to SETUP; boot rises 1 edge after acceptance; armed never asserts.
6. Drop rst_n asynchronously mid-SETUP and mid-BOOT -> boot, s1, s0, busy go to 0 without waiting for a clk edge; after release, state is IDLE with req_ready=1.

Source files
------------

// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: sequences the iCE40 SB_WARMBOOT inputs (S1, S0, BOOT).
// A single image-select request is accepted in IDLE. The controller then waits
// a cancellable arming delay and holds the image lines stable for a setup
// window. After that it raises BOOT and keeps it high until reset.
module warmboot_ctrl #(
  parameter int unsigned DELAY_CYCLES = 120_000_000,
  parameter int unsigned SETUP_CYCLES = 16,
  parameter int unsigned CNT_W        = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_image,
  output logic       req_ready,
  input  logic       cancel,
  output logic       armed,
  output logic       busy,
  output logic       s1,
  output logic       s0,
  output logic       boot
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SETUP = 2'd2,
    ST_BOOT  = 2'd3
  } state_t;

  localparam longint unsigned MAX_TERM =
    (DELAY_CYCLES > SETUP_CYCLES) ? longint'(DELAY_CYCLES) : longint'(SETUP_CYCLES);

  // Terminal counts; DLY_LAST is unused when the arming delay is zero.
  localparam logic [CNT_W-1:0] DLY_LAST =
    (DELAY_CYCLES == 0) ? '0 : CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETUP_CYCLES - 1);

  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("warmboot_ctrl: SETUP_CYCLES must be >= 1");
  end

  if (CNT_W < 64 && (64'd1 << CNT_W) <= MAX_TERM) begin : g_bad_cnt_w
    $error("warmboot_ctrl: CNT_W too narrow for DELAY_CYCLES/SETUP_CYCLES");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       img_q, img_d;
  logic             req_ready_q, req_ready_d;
  logic             armed_q, armed_d;
  logic             busy_q, busy_d;
  logic             s1_q, s1_d;
  logic             s0_q, s0_d;
  logic             boot_q, boot_d;

  // Next-state, counter and image-latch logic for the boot sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    img_d   = img_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          img_d   = req_image;
          cnt_d   = '0;
          state_d = (DELAY_CYCLES == 0) ? ST_SETUP : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          img_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == SET_LAST) begin
          state_d = ST_BOOT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BOOT: begin
        state_d = ST_BOOT;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        img_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next state. Registering them gives the primitive
  // glitch-free pins with the same timing as a decode of the current state.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    armed_d     = (state_d == ST_ARMED);
    busy_d      = (state_d != ST_IDLE);
    boot_d      = (state_d == ST_BOOT);
    s1_d        = busy_d & img_d[1];
    s0_d        = busy_d & img_d[0];
  end

  // State, counter, latch and output registers; reset is asynchronous so BOOT
  // drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      img_q       <= '0;
      req_ready_q <= 1'b1;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      s1_q        <= 1'b0;
      s0_q        <= 1'b0;
      boot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      img_q       <= img_d;
      req_ready_q <= req_ready_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      boot_q      <= boot_d;
    end
  end

  assign req_ready = req_ready_q;
  assign armed     = armed_q;
  assign busy      = busy_q;
  assign s1        = s1_q;
  assign s0        = s0_q;
  assign boot      = boot_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Testbench for warmboot_ctrl with two instances: (10,4) and (0,1).
// Each request pushes its expected boot event (image and cycle) into a queue.
// Separate monitors pop the queue and compare when boot rises.
module tb_warmboot_ctrl;

  localparam int unsigned DA = 10;
  localparam int unsigned SA = 4;
  localparam int unsigned DB = 0;
  localparam int unsigned SB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_req_valid, a_cancel, a_req_ready, a_armed, a_busy, a_s1, a_s0, a_boot;
  logic [1:0] a_req_image;
  logic       b_req_valid, b_cancel, b_req_ready, b_armed, b_busy, b_s1, b_s0, b_boot;
  logic [1:0] b_req_image;

  warmboot_ctrl #(.DELAY_CYCLES(DA), .SETUP_CYCLES(SA), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_image(a_req_image),
    .req_ready(a_req_ready), .cancel(a_cancel), .armed(a_armed), .busy(a_busy),
    .s1(a_s1), .s0(a_s0), .boot(a_boot)
  );

  warmboot_ctrl #(.DELAY_CYCLES(DB), .SETUP_CYCLES(SB), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_image(b_req_image),
    .req_ready(b_req_ready), .cancel(b_cancel), .armed(b_armed), .busy(b_busy),
    .s1(b_s1), .s0(b_s0), .boot(b_boot)
  );

  typedef struct {
    logic [1:0]  img;
    int unsigned at;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a, e_b;
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic        a_boot_prev = 1'b0;
  logic        b_boot_prev = 1'b0;
  logic        b_armed_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Scoreboard monitor for instance A: compare on each boot rising edge.
  always @(negedge clk) begin
    if (a_boot && !a_boot_prev) begin
      if (q_a.size() == 0) check("a_unexpected_boot", 32'(1), 32'(0));
      else begin
        e_a = q_a.pop_front();
        check("a_boot_cycle", cyc, e_a.at);
        check("a_boot_image", 32'({a_s1, a_s0}), 32'(e_a.img));
      end
    end
    a_boot_prev <= a_boot;
  end

  // Scoreboard monitor for instance B.
  always @(negedge clk) begin
    if (b_boot && !b_boot_prev) begin
      if (q_b.size() == 0) check("b_unexpected_boot", 32'(1), 32'(0));
      else begin
        e_b = q_b.pop_front();
        check("b_boot_cycle", cyc, e_b.at);
        check("b_boot_image", 32'({b_s1, b_s0}), 32'(e_b.img));
      end
    end
    if (b_armed) b_armed_seen <= 1'b1;
    b_boot_prev <= b_boot;
  end

  task automatic req_a(input logic [1:0] img, input bit exp_boot, input bit hold);
    @(negedge clk);
    check("a_ready_before_req", 32'(a_req_ready), 32'(1));
    a_req_valid = 1'b1;
    a_req_image = img;
    @(negedge clk);
    if (!hold) begin
      a_req_valid = 1'b0;
      a_req_image = 2'b00;
    end
    if (exp_boot) q_a.push_back('{img, cyc + DA + SA});
    check("a_ready_dropped", 32'(a_req_ready), 32'(0));
    check("a_s1s0_latched", 32'({a_s1, a_s0}), 32'(img));
    check("a_armed_at_accept", 32'(a_armed), 32'(1));
  endtask

  task automatic wait_boot_a();
    int n = 0;
    while (!a_boot && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a_boot_rise_timeout", 32'(a_boot), 32'(1));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_boot", 32'(a_boot), 32'(0));
    check("rst_async_s1s0", 32'({a_s1, a_s0}), 32'(0));
    check("rst_async_busy", 32'(a_busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(a_req_ready), 32'(1));
    check("rst_release_busy", 32'(a_busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_image = 2'b00; a_cancel = 1'b0;
    b_req_valid = 1'b0; b_req_image = 2'b00; b_cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(a_req_ready), 32'(1));
    check("reset_outputs", 32'({a_armed, a_busy, a_s1, a_s0, a_boot}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: nominal boot of image 2'b10.
    req_a(2'b10, 1'b1, 1'b0);
    n = 0;
    while (a_armed && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("a_armed_length", 32'(n), 32'(DA));
    wait_boot_a();
    repeat (5) begin
      @(negedge clk);
      check("a_boot_held", 32'({a_boot, a_busy, a_req_ready}), 32'(3'b110));
      check("a_s1s0_in_boot", 32'({a_s1, a_s0}), 32'(2'b10));
    end
    // 6a: asynchronous reset while in BOOT.
    async_reset();

    // 2: cancel on the 5th ARMED cycle, then a fresh request.
    req_a(2'b01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    a_cancel = 1'b1;
    @(negedge clk);
    a_cancel = 1'b0;
    check("a_cancel_idle", 32'({a_req_ready, a_armed, a_busy, a_s1, a_s0}), 32'(5'b10000));
    repeat (20) @(negedge clk);
    check("a_cancel_no_boot", 32'(a_boot), 32'(0));
    req_a(2'b11, 1'b1, 1'b0);
    wait_boot_a();
    async_reset();

    // 3: cancel at the terminal ARMED count wins; cancel in SETUP is ignored.
    req_a(2'b10, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    a_cancel = 1'b1;
    @(negedge clk);
    a_cancel = 1'b0;
    check("a_cancel_at_tc", 32'({a_req_ready, a_armed, a_busy}), 32'(3'b100));
    repeat (10) @(negedge clk);
    check("a_cancel_at_tc_no_boot", 32'(a_boot), 32'(0));
    req_a(2'b11, 1'b1, 1'b0);
    repeat (11) @(negedge clk);
    a_cancel = 1'b1;
    @(negedge clk);
    a_cancel = 1'b0;
    check("a_setup_ignores_cancel", 32'({a_busy, a_armed, a_boot}), 32'(3'b100));
    wait_boot_a();
    async_reset();

    // 4: req_valid held with changing image while busy.
    req_a(2'b01, 1'b1, 1'b1);
    n = 0;
    while (!a_boot && n < 100) begin
      a_req_image = a_req_image + 2'd1;
      @(negedge clk);
      check("a_image_stable", 32'({a_s1, a_s0, a_req_ready}), 32'(3'b010));
      n++;
    end
    check("a_boot_rise_held_req", 32'(a_boot), 32'(1));
    repeat (3) begin
      a_req_image = a_req_image + 2'd1;
      @(negedge clk);
      check("a_image_stable_boot", 32'({a_s1, a_s0, a_boot}), 32'(3'b011));
    end
    a_req_valid = 1'b0;
    async_reset();

    // 6b: asynchronous reset mid-SETUP.
    req_a(2'b10, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    check("a_in_setup", 32'({a_busy, a_armed, a_boot}), 32'(3'b100));
    async_reset();
    repeat (20) @(negedge clk);
    check("a_no_boot_after_setup_reset", 32'(a_boot), 32'(0));

    // 5: zero arming delay, one setup cycle.
    @(negedge clk);
    check("b_ready", 32'(b_req_ready), 32'(1));
    b_req_valid = 1'b1;
    b_req_image = 2'b10;
    @(negedge clk);
    b_req_valid = 1'b0;
    q_b.push_back('{2'b10, cyc + DB + SB});
    check("b_setup_direct", 32'({b_armed, b_busy, b_boot, b_s1, b_s0}), 32'(5'b01010));
    @(negedge clk);
    check("b_boot_one_edge", 32'(b_boot), 32'(1));
    repeat (3) @(negedge clk);

    check("a_sb_drained", q_a.size(), 32'(0));
    check("b_sb_drained", q_b.size(), 32'(0));
    check("b_armed_never", 32'(b_armed_seen), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
